// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder/subtractor: one STAGE_BITS slice per stage, with input skew
// and output deskew so that a new operation can enter on every enabled cycle.
module pipelined_rca_adder #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned STAGE_BITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    output logic [WIDTH-1:0] Sum,
    output logic             carry_out,
    output logic             overflow
);
    localparam int unsigned SB     = STAGE_BITS;
    localparam int unsigned STAGES = WIDTH / STAGE_BITS;

    if ((WIDTH % STAGE_BITS) != 0) begin : g_cfg_err
        $error("pipelined_rca_adder: WIDTH must be a multiple of STAGE_BITS");
    end

    logic [WIDTH-1:0]  a_ent_c;
    logic [WIDTH-1:0]  b_ent_c;
    logic [STAGES:0]   carry;
    logic [STAGES-1:0] vld_q;
    logic              ov_q;

    // Bubbles enter as all-zero operands so idle output data stays deterministic
    assign a_ent_c  = in_valid ? A : '0;
    assign b_ent_c  = in_valid ? (sub ? ~B : B) : '0;
    assign carry[0] = in_valid & (sub | carry_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else if (en) begin
            vld_q[0] <= in_valid;
            for (int i = 1; i < STAGES; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        localparam int unsigned DSK = STAGES - 1 - k;

        logic [SB-1:0] a_c;
        logic [SB-1:0] b_c;
        logic [SB:0]   add_c;
        logic [SB-1:0] s_q;
        logic          co_q;

        if (k == 0) begin : g_entry
            assign a_c = a_ent_c[SB-1:0];
            assign b_c = b_ent_c[SB-1:0];
        end else begin : g_skew
            // Slice k waits k cycles so it meets its own operation's carry
            logic [SB-1:0] a_sk [k];
            logic [SB-1:0] b_sk [k];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int j = 0; j < k; j++) begin
                        a_sk[j] <= '0;
                        b_sk[j] <= '0;
                    end
                end else if (en) begin
                    a_sk[0] <= a_ent_c[k*SB +: SB];
                    b_sk[0] <= b_ent_c[k*SB +: SB];
                    for (int j = 1; j < k; j++) begin
                        a_sk[j] <= a_sk[j-1];
                        b_sk[j] <= b_sk[j-1];
                    end
                end
            end

            assign a_c = a_sk[k-1];
            assign b_c = b_sk[k-1];
        end

        assign add_c = (SB+1)'(a_c) + (SB+1)'(b_c) + (SB+1)'(carry[k]);

        always_ff @(posedge clk) begin
            if (rst) begin
                s_q  <= '0;
                co_q <= 1'b0;
            end else if (en) begin
                s_q  <= add_c[SB-1:0];
                co_q <= add_c[SB];
            end
        end

        assign carry[k+1] = co_q;

        if (k == STAGES - 1) begin : g_msb
            // Carry into the MSB recovered from the MSB sum bit
            logic msb_cin_c;

            assign msb_cin_c = a_c[SB-1] ^ b_c[SB-1] ^ add_c[SB-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    ov_q <= 1'b0;
                end else if (en) begin
                    ov_q <= msb_cin_c ^ add_c[SB];
                end
            end
        end

        if (DSK == 0) begin : g_out
            assign Sum[k*SB +: SB] = s_q;
        end else begin : g_deskew
            logic [SB-1:0] ds_q [DSK];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int j = 0; j < DSK; j++) begin
                        ds_q[j] <= '0;
                    end
                end else if (en) begin
                    ds_q[0] <= s_q;
                    for (int j = 1; j < DSK; j++) begin
                        ds_q[j] <= ds_q[j-1];
                    end
                end
            end

            assign Sum[k*SB +: SB] = ds_q[DSK-1];
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign carry_out = carry[STAGES];
    assign overflow  = ov_q;

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Scoreboard bench for pipelined_rca_adder: an 8-bit/2-bit-slice instance and a
// 4-bit/1-bit-slice instance share stimulus; both have a latency of 4 enabled cycles.
module tb_pipelined_rca_adder;
    localparam int STG = 4;

    typedef struct packed {
        logic [7:0] sum;
        logic       co;
        logic       ov;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, en, in_valid, carry_in, sub;
    logic [7:0] A, B;
    logic       out_valid, carry_out, overflow;
    logic [7:0] Sum;
    logic       v4, co4, ov4;
    logic [3:0] s4;

    int n_checks = 0;
    int n_fail   = 0;
    int edges    = 0;

    exp_t        sb_q [2][$];
    logic [10:0] snap [2];
    logic [10:0] last_snap [2];
    logic        s_rst, s_en, s_v, s_c, s_sub;
    logic [7:0]  s_a, s_b;

    pipelined_rca_adder #(.WIDTH(8), .STAGE_BITS(2)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
        .A(A), .B(B), .carry_in(carry_in), .sub(sub),
        .out_valid(out_valid), .Sum(Sum), .carry_out(carry_out), .overflow(overflow)
    );

    pipelined_rca_adder #(.WIDTH(4), .STAGE_BITS(1)) dut4 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
        .A(A[3:0]), .B(B[3:0]), .carry_in(carry_in), .sub(sub),
        .out_valid(v4), .Sum(s4), .carry_out(co4), .overflow(ov4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference result for a w-bit adder; overflow from operand/result sign rule
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic c,
                                   input logic s, input int w, input int due);
        logic [8:0] full;
        logic [7:0] mask, aa, bb;
        exp_t       e;
        mask  = 8'((9'd1 << w) - 9'd1);
        aa    = a & mask;
        bb    = (s ? ~b : b) & mask;
        full  = 9'(aa) + 9'(bb) + 9'(s | c);
        e.sum = full[7:0] & mask;
        e.co  = full[w];
        e.ov  = (aa[w-1] == bb[w-1]) && (e.sum[w-1] != aa[w-1]);
        e.due = due;
        return e;
    endfunction

    task automatic score(input int id, input logic vld, input logic [7:0] sum,
                         input logic co, input logic ov);
        exp_t e;
        logic exp_v;
        exp_v = (sb_q[id].size() != 0) && (sb_q[id][0].due == edges);
        check($sformatf("u%0d_valid", id), 32'(vld), 32'(exp_v));
        if (exp_v) begin
            e = sb_q[id].pop_front();
            if (vld) begin
                check($sformatf("u%0d_sum", id), 32'(sum), 32'(e.sum));
                check($sformatf("u%0d_cout", id), 32'(co), 32'(e.co));
                check($sformatf("u%0d_ovf", id), 32'(ov), 32'(e.ov));
            end
        end
    endtask

    // Monitor: inputs taken at the edge, outputs 1 time unit after it
    always @(posedge clk) begin
        s_rst = rst; s_en = en; s_v = in_valid;
        s_a = A; s_b = B; s_c = carry_in; s_sub = sub;
        #1;
        snap[0] = {out_valid, overflow, carry_out, Sum};
        snap[1] = {v4, ov4, co4, 4'b0, s4};
        if (s_rst) begin
            for (int id = 0; id < 2; id++) begin
                sb_q[id].delete();
                check($sformatf("u%0d_reset", id), 32'(snap[id]), 32'd0);
            end
        end else if (s_en) begin
            edges++;
            if (s_v) begin
                sb_q[0].push_back(model(s_a, s_b, s_c, s_sub, 8, edges + STG - 1));
                sb_q[1].push_back(model(s_a, s_b, s_c, s_sub, 4, edges + STG - 1));
            end
            score(0, out_valid, Sum, carry_out, overflow);
            score(1, v4, {4'b0, s4}, co4, ov4);
        end else begin
            for (int id = 0; id < 2; id++) begin
                check($sformatf("u%0d_stall_hold", id), 32'(snap[id]), 32'(last_snap[id]));
            end
        end
        last_snap = snap;
    end

    task automatic drive(input logic r, input logic e, input logic v, input logic [7:0] a,
                         input logic [7:0] b, input logic c, input logic s);
        @(negedge clk);
        rst = r; en = e; in_valid = v; A = a; B = b; carry_in = c; sub = s;
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
        drive(1'b0, 1'b1, 1'b1, a, b, c, s);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; in_valid = 1'b1;
        A = 8'h00; B = 8'h00; carry_in = 1'b0; sub = 1'b0;

        // Reset held with live random operations, then idle outputs must stay zero
        repeat (2) drive(1'b1, 1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
            @(posedge clk);
            #2;
            check("post_reset_idle8", 32'({out_valid, overflow, carry_out, Sum}), 32'd0);
            check("post_reset_idle4", 32'({v4, ov4, co4, s4}), 32'd0);
        end

        // Signed overflow on add; subtract with and without borrow
        issue(8'h7F, 8'h01, 1'b0, 1'b0);
        idle(5);
        issue(8'h10, 8'h20, 1'b1, 1'b1);
        issue(8'h80, 8'h01, 1'b0, 1'b1);
        idle(5);

        // Back-to-back carry-propagating operations
        issue(8'hFF, 8'h01, 1'b0, 1'b0);
        issue(8'hFF, 8'h00, 1'b1, 1'b0);
        issue(8'h55, 8'hAA, 1'b0, 1'b0);
        idle(6);

        // Stall mid-flight; in_valid high while stalled must not be accepted
        issue(8'h3C, 8'h4D, 1'b1, 1'b0);
        issue(8'hC3, 8'h9A, 1'b0, 1'b1);
        repeat (3) drive(1'b0, 1'b0, 1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b0);
        idle(6);

        // Reset discards in-flight operations; the next one returns normally
        issue(8'h12, 8'h34, 1'b0, 1'b0);
        issue(8'hF0, 8'h0F, 1'b1, 1'b0);
        issue(8'h01, 8'h02, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 8'hAA, 8'h55, 1'b1, 1'b0);
        issue(8'h9C, 8'h27, 1'b1, 1'b0);
        idle(6);

        // Random traffic with bubbles and stalls
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 3) != 0),
                  8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        end
        idle(8);

        check("u0_drained", 32'(sb_q[0].size()), 32'd0);
        check("u1_drained", 32'(sb_q[1].size()), 32'd0);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipelined_rca_adder.md
Name: pipelined_rca_adder

Overview:
Parametrised pipelined ripple-carry adder/subtractor. It splits a WIDTH-bit operation into STAGES = WIDTH/STAGE_BITS slices, one slice per clock stage. The block uses input skew and output deskew registers so that one operation can be accepted every cycle. It is the datapath adder for the lab-series arithmetic units and adds three things to the fixed 4-bit, 1-bit-per-stage version: valid tracking, pipeline stall, and subtract mode with signed overflow.

Parameters:
WIDTH, 8, operand and sum width in bits; must be a multiple of STAGE_BITS.
STAGE_BITS, 2, bits resolved per pipeline stage.
STAGES (derived, localparam), WIDTH/STAGE_BITS, pipeline depth and latency in cycles.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
en  input  1  pipeline advance; when 0, every register holds.
in_valid  input  1  A/B/carry_in/sub are a valid operation this cycle.
A  input  WIDTH  operand A (unsigned or two's complement).
B  input  WIDTH  operand B.
carry_in  input  1  carry into bit 0 (add mode only).
sub  input  1  0: A+B+carry_in; 1: A-B.
out_valid  output  1  Sum/carry_out/overflow hold a completed operation.
Sum  output  WIDTH  result.
carry_out  output  1  carry out of MSB (in subtract mode, 1 = no borrow).
overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst, which has priority over en.
- Reset: all skew, stage, deskew and valid registers clear to 0. out_valid=0, Sum=0, carry_out=0, overflow=0.
- Reset mid-operation discards every in-flight operation. in_valid is ignored while rst=1. The first operation accepted after rst falls appears STAGES cycles later.
- Accept: an operation is accepted on a rising edge where en=1 and in_valid=1.
- Operand conditioning at entry, combinational before skew:
  - B_eff = sub ? ~B : B.
  - cin_eff = sub ? 1 : carry_in. carry_in is ignored when sub=1.
- Input skew: slice k (bits k*STAGE_BITS +: STAGE_BITS) of A and B_eff is delayed k register stages before reaching adder stage k.
- Stage k: {c_k+1, s_k} = A_k + B_k + c_k, registered. c_0 = cin_eff, registered with slice 0. The carry register of stage k feeds stage k+1 on the next cycle.
- Stage STAGES-1 also registers the carry into its MSB so that overflow can be computed.
- Output deskew: sum slice k is delayed STAGES-1-k further stages. All slices, carry_out, overflow and out_valid align at the output.
- Latency: exactly STAGES enabled cycles from accept to out_valid=1 with the matching result.
- Throughput: 1 operation per enabled cycle. Back-to-back operations must not corrupt each other; each carry travels with its own operation's wavefront.
- Valid: a STAGES-deep valid shift register advances only when en=1.
  - Bubbles (in_valid=0) propagate as out_valid=0.
  - Sum/carry_out/overflow during a bubble are don't-care but must be deterministic (no X after reset).
- Stall: while en=0, no register changes. Outputs, including out_valid, hold their last values. Latency measured in clk cycles grows by exactly the number of stalled cycles.
- Arithmetic is modulo 2^WIDTH; carry_out is the true bit WIDTH.
- Degenerate case STAGE_BITS=WIDTH: STAGES=1, single registered adder, latency 1.
- Parameter check: WIDTH % STAGE_BITS != 0 is a configuration error, flagged by elaboration-time $error.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with in_valid=1 and random operands. Release rst and hold in_valid=0 -> out_valid=0, Sum=0x00, carry_out=0, overflow=0 on every cycle, with no X.
2. Add, WIDTH=8, STAGE_BITS=2: A=0x7F, B=0x01, carry_in=0, sub=0 -> exactly 4 cycles later out_valid=1, Sum=0x80, carry_out=0, overflow=1.
3. Subtract: A=0x10, B=0x20, sub=1, carry_in=1 (ignored) -> Sum=0xF0, carry_out=0, overflow=0. Then A=0x80, B=0x01, sub=1 -> Sum=0x7F, carry_out=1, overflow=1.
4. Back-to-back, one per cycle:
   - 0xFF+0x01 cin=0 -> 0x00, carry_out=1.
   - 0xFF+0x00 cin=1 -> 0x00, carry_out=1.
   - 0x55+0xAA cin=0 -> 0xFF, carry_out=0.
   - Results appear on 3 consecutive cycles after latency 4, in order.
5. Stall: issue 2 operations, then drop en for 3 cycles mid-flight -> results appear 3 cycles late with unchanged values. Outputs hold steady during the stall.
6. Reset mid-flight with STAGES=4 (WIDTH=4, STAGE_BITS=1 also run): issue 3 operations, assert rst for 1 cycle two cycles later -> no out_valid=1 for the discarded operations. The next operation accepted after reset returns its correct result 4 cycles after acceptance.
